// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and constants for the serial 2-bit-slice adder controller.
package serial_add_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of the slice index; kept at least 1 bit so WIDTH=2 still elaborates.
  function automatic int idx_width(input int width);
    return (width > 2) ? $clog2(width / 2) : 1;
  endfunction

endpackage

// File: rtl/serial_add_ctrl_add2_slice.sv
// Combinational 2-bit adder slice: {co, s} = a + b + ci.
module add2_slice (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       ci,
  output logic [1:0] s,
  output logic       co
);

  logic [2:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {2'b00, ci};
  assign s     = total[1:0];
  assign co    = total[2];

endmodule

// File: rtl/serial_add_ctrl.sv
// Adds two WIDTH-bit operands plus carry-in by stepping one 2-bit slice over
// WIDTH/2 cycles, LSB pair first, behind a valid/ready request/response pair.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output state_e           dbg_state_o
);

  // Handshake: a request transfers on a rising edge where in_valid && in_ready,
  // a result transfers where out_valid && out_ready; neither side may retract
  // a raised valid before its transfer, and ready never depends on valid.

  localparam int              NSL    = WIDTH / 2;
  localparam int              KW     = idx_width(WIDTH);
  localparam logic [KW-1:0]   K_LAST = KW'(NSL - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [KW-1:0]    k_q, k_d;

  logic [1:0]       slice_a, slice_b, slice_s;
  logic             slice_co;
  logic             last_slice;

  assign slice_a    = a_q[{k_q, 1'b0} +: 2];
  assign slice_b    = b_q[{k_q, 1'b0} +: 2];
  assign last_slice = (k_q == K_LAST);

  add2_slice u_slice (
    .a  (slice_a),
    .b  (slice_b),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)   state_d = RUN;
      RUN:     if (last_slice) state_d = DONE;
      DONE:    if (out_ready)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs, decoded from the registered state only.
  always_comb begin
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    dbg_state_o = state_q;
    unique case (state_q)
      IDLE:    in_ready  = 1'b1;
      RUN:     busy      = 1'b1;
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
      end
      default: in_ready  = 1'b1;
    endcase
  end

  // Datapath next-state: operands latch only on acceptance, sum only in RUN.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    k_d     = k_q;
    if (state_q == IDLE && in_valid) begin
      a_d     = a;
      b_d     = b;
      carry_d = cin;
      k_d     = '0;
    end else if (state_q == RUN) begin
      sum_d[{k_q, 1'b0} +: 2] = slice_s;
      carry_d                 = slice_co;
      if (last_slice) begin
        cout_d = slice_co;
      end else begin
        k_d = k_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      k_q     <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      k_q     <= k_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: vector table, corner sequences, random traffic.
module tb_serial_add_ctrl;
  import serial_add_ctrl_pkg::*;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;
  state_e       dbg_state;

  logic [W:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .cin         (cin),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .sum         (sum),
    .cout        (cout),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  64'(in_ready),  64'(1));
    check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    check({tag, "_busy"},      64'(busy),      64'(0));
    check({tag, "_sum"},       64'(sum),       64'(0));
    check({tag, "_cout"},      64'(cout),      64'(0));
  endtask

  // One full transaction. hold = cycles out_ready stays low in DONE;
  // poke = drive in_valid with junk operands while in DONE and on the
  // release edge, which must not be accepted.
  task automatic do_req(input logic [W-1:0] ta, input logic [W-1:0] tb_op, input logic tc,
                        input logic [W:0] exp, input int hold, input bit poke);
    int         lat;
    logic [W:0] e;
    logic [W:0] got;
    logic [W:0] snap;
    @(negedge clk);
    check("in_ready_idle", 64'(in_ready), 64'(1));
    a        = ta;
    b        = tb_op;
    cin      = tc;
    in_valid = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    lat = 0;
    while (!out_valid && lat < 20) begin
      check("in_ready_run", 64'(in_ready), 64'(0));
      check("busy_run",     64'(busy),     64'(1));
      in_valid = 1'($urandom_range(0, 1));
      a        = W'($urandom);
      b        = W'($urandom);
      cin      = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    check("latency", 64'(lat), 64'(W / 2));
    if (!out_valid) begin
      void'(exp_q.pop_front());
      rst_n = 1'b0;
      #3 rst_n = 1'b1;
      return;
    end
    check("in_ready_done", 64'(in_ready), 64'(0));
    snap = {cout, sum};
    for (int i = 0; i < hold; i++) begin
      in_valid = poke;
      a        = W'($urandom);
      b        = W'($urandom);
      @(posedge clk); #1;
      check("hold_valid",  64'(out_valid),   64'(1));
      check("hold_stable", 64'({cout, sum}), 64'(snap));
    end
    got = {cout, sum};
    e   = exp_q.pop_front();
    check("result", 64'(got), 64'(e));
    out_ready = 1'b1;
    in_valid  = poke;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("post_out_valid", 64'(out_valid), 64'(0));
    check("post_busy",      64'(busy),      64'(0));
    check("post_sum_held",  64'({cout, sum}), 64'(got));
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  vec_t tv[8];

  initial begin
    bit saw_valid;
    logic [W-1:0] ra, rb;
    logic         rc;

    tv[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    tv[1] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0};
    tv[2] = '{16'h0001, 16'h0000, 1'b0, 16'h0001, 1'b0};
    tv[3] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
    tv[4] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
    tv[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    tv[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    tv[7] = '{16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tv[i]) begin
      do_req(tv[i].a, tv[i].b, tv[i].cin, {tv[i].exp_cout, tv[i].exp_sum}, 0, 1'b0);
    end

    // Stalled consumer with in_valid pulses in DONE and on the release edge.
    do_req(16'hAAAA, 16'h5555, 1'b1, {1'b1, 16'h0000}, 5, 1'b1);

    // Reset in the middle of RUN: nothing may be delivered.
    @(negedge clk);
    a        = 16'h1111;
    b        = 16'h2222;
    cin      = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_run_reset");
    saw_valid = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) saw_valid = 1'b1;
    end
    check("no_result_after_abort", 64'(saw_valid), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    do_req(16'h0003, 16'h0005, 1'b0, {1'b0, 16'h0008}, 0, 1'b0);

    for (int n = 0; n < 20; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom_range(0, 1));
      do_req(ra, rb, rc, model(ra, rb, rc), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter: WIDTH, default 16, operand width in bits; SHALL be even and at least 2.
REQ-002 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 Port: in_valid  in  1  operand request from the requester.
REQ-005 Port: in_ready  out  1  controller can accept operands.
REQ-006 Port: a  in  WIDTH  operand A.
REQ-007 Port: b  in  WIDTH  operand B.
REQ-008 Port: cin  in  1  carry-in.
REQ-009 Port: out_valid  out  1  result available.
REQ-010 Port: out_ready  in  1  consumer accepts the result.
REQ-011 Port: sum  out  WIDTH  registered sum.
REQ-012 Port: cout  out  1  registered final carry-out.
REQ-013 Port: busy  out  1  high in RUN and DONE.

Function
REQ-014 The block SHALL add two WIDTH-bit operands plus cin by sequencing a single 2-bit adder slice over WIDTH/2 cycles, LSB pair first.
REQ-015 FSM states SHALL be IDLE, RUN and DONE only.
REQ-016 IDLE: in_ready=1, out_valid=0; on in_valid&in_ready, latch a, b, carry<=cin, slice index<=0, go to RUN.
REQ-017 RUN: each cycle slice k adds a[2k+1:2k], b[2k+1:2k] and carry, writes sum[2k+1:2k], updates carry, and increments k.
REQ-018 RUN: when k=WIDTH/2-1 completes, cout<=final carry and the FSM goes to DONE; k SHALL NOT wrap past WIDTH/2-1.
REQ-019 Latency: out_valid SHALL rise exactly WIDTH/2 clock edges after the accepting edge (8 for WIDTH=16).
REQ-020 DONE: out_valid=1; sum and cout held stable until out_valid&out_ready, then return to IDLE.
REQ-021 in_ready SHALL be 0 in RUN and DONE; in_valid and operand changes in those states SHALL be ignored.
REQ-022 DONE with out_ready=1: transfer completes and the FSM goes to IDLE; a new request is accepted no earlier than the following edge (no same-cycle turnaround).
REQ-023 Sum arithmetic SHALL be modulo 2^WIDTH; cout SHALL equal bit WIDTH of a+b+cin.
REQ-024 sum and cout SHALL change only in RUN (per slice) and at reset.

Reset
REQ-025 On rst_n low, immediately and independent of clk: state=IDLE, k=0, carry=0, sum=0, cout=0, out_valid=0, busy=0, in_ready=1.
REQ-026 Reset asserted mid-RUN or in DONE SHALL abort the operation with no result delivered.
REQ-027 After rst_n deasserts, the first request SHALL be accepted on the first edge with in_valid=1.

Structure
REQ-028 Shared package SHALL hold the state enum (IDLE, RUN, DONE) and the default WIDTH constant.
REQ-029 The 2-bit slice SHALL be a combinational sub-module add2_slice (inputs a[1:0], b[1:0], ci; outputs s[1:0], co) instantiated once.
REQ-030 The controller SHALL contain no second adder; all sum bits SHALL come through add2_slice.

Verification
REQ-031 a=0xFFFF, b=0x0001, cin=0 -> after 8 cycles out_valid=1, sum=0x0000, cout=1.
REQ-032 a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0; in_ready=0 for all 9 cycles from the accepting edge through DONE.
REQ-033 Result 0xAAAA+0x5555, cin=1, out_ready held 0 for 5 cycles -> sum=0x0000, cout=1 stable, in_valid pulses ignored; accepted on the out_ready edge, IDLE next.
REQ-034 rst_n pulsed low at RUN cycle 4 -> all outputs immediately at reset values, no out_valid; next request 0x0003+0x0005 -> 0x0008, cout=0.
REQ-035 Operands changed during RUN (a 0x0001->0xFFFF) -> result still uses the latched value.
REQ-036 Random back-to-back requests with random out_ready -> every result matches a+b+cin against a reference model, latency always 8.
